icap_reg_reader: RTL and testbench

ICAP_REG_READER -- requirements
Module: icap_reg_reader

---
 rtl/icap_reg_reader_if.sv | 24 ++
 rtl/icap_reg_reader.sv | 144 ++++++++++++++
 tb/tb_icap_reg_reader.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/icap_reg_reader_if.sv
// Request/response and ICAPE2 pin bundle for icap_reg_reader.
// slave = the reader; master = the parent that issues requests and owns the ICAPE2 primitive.
interface icap_reg_reader_if;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        boot_done;
  logic [31:0] icap_i;
  logic        icap_csib;
  logic        icap_rdwrb;
  logic [31:0] icap_o;

  modport slave (
    input  req_valid, req_addr, icap_o,
    output req_ready, rsp_valid, rsp_data, boot_done, icap_i, icap_csib, icap_rdwrb
  );

  modport master (
    output req_valid, req_addr, icap_o,
    input  req_ready, rsp_valid, rsp_data, boot_done, icap_i, icap_csib, icap_rdwrb
  );
endinterface

// File: rtl/icap_reg_reader.sv
// Reads one type-1 configuration register through ICAPE2: sync, read header, read window, desync.
// Macro ICAP_REG_READER_BITSWAP_EN: reverse bits within each byte on icap_i/icap_o (direct ICAPE2 hookup).
module icap_reg_reader #(
  parameter int unsigned BOOT_CYCLES  = 8388607,
  parameter int unsigned READ_LATENCY = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  icap_reg_reader_if.slave bus
);
  // BOOT_CYCLES == 0 is treated as 1 so the boot counter never wraps
  localparam int unsigned BOOT_LAST = (BOOT_CYCLES == 0) ? 0 : BOOT_CYCLES - 1;
  localparam int unsigned CW_B      = $clog2(BOOT_LAST + 1);
  localparam int unsigned CW        = (CW_B < 4) ? 4 : CW_B;

  localparam logic [31:0] W_DUMMY  = 32'hFFFF_FFFF;
  localparam logic [31:0] W_SYNC   = 32'hAA99_5566;
  localparam logic [31:0] W_NOOP   = 32'h2000_0000;
  localparam logic [31:0] W_HDR    = 32'h2800_0001;
  localparam logic [31:0] W_CMD_WR = 32'h3000_8001;
  localparam logic [31:0] W_DESYNC = 32'h0000_000D;

  typedef enum logic [2:0] {BOOT, IDLE, SYNC, HEADER, PIPE, TURN, READ, DESYNC} state_t;

  function automatic logic [31:0] wire_fmt(input logic [31:0] w);
`ifdef ICAP_REG_READER_BITSWAP_EN
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++)
      for (int g = 0; g < 8; g++)
        r[b*8+g] = w[b*8+7-g];
    return r;
`else
    return w;
`endif
  endfunction

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [4:0]    addr_q, addr_n;
  logic [31:0]   cap_q, cap_n, rsp_data_n, word, icap_i_n;
  logic          boot_done_n, req_ready_n, rsp_valid_n, csib_n, rdwrb_n;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    addr_n      = addr_q;
    cap_n       = cap_q;
    rsp_data_n  = bus.rsp_data;
    boot_done_n = bus.boot_done;
    rsp_valid_n = 1'b0;
    case (state)
      BOOT:
        if (cnt == CW'(BOOT_LAST)) begin
          state_n = IDLE; cnt_n = '0; boot_done_n = 1'b1;
        end else cnt_n = cnt + CW'(1);
      IDLE:
        if (bus.req_valid) begin
          state_n = SYNC; cnt_n = '0; addr_n = bus.req_addr;
        end
      SYNC:
        if (cnt == CW'(3)) begin state_n = HEADER; cnt_n = '0; end
        else cnt_n = cnt + CW'(1);
      HEADER: begin state_n = PIPE; cnt_n = '0; end
      PIPE:
        if (cnt == CW'(3)) begin state_n = TURN; cnt_n = '0; end
        else cnt_n = cnt + CW'(1);
      TURN:
        if (cnt == CW'(1)) begin state_n = READ; cnt_n = CW'(1); end
        else cnt_n = cnt + CW'(1);
      READ: begin
        if (cnt == CW'(READ_LATENCY)) cap_n = wire_fmt(bus.icap_o);
        // rsp_data only moves together with the rsp_valid pulse
        if (cnt == CW'(8)) begin
          state_n = DESYNC; cnt_n = '0; rsp_valid_n = 1'b1; rsp_data_n = cap_q;
        end else cnt_n = cnt + CW'(1);
      end
      DESYNC:
        if (cnt == CW'(8)) begin state_n = IDLE; cnt_n = '0; end
        else cnt_n = cnt + CW'(1);
      default: begin state_n = BOOT; cnt_n = '0; end
    endcase

    // Outputs are decoded from the next state so they register in step with it
    csib_n      = 1'b1;
    rdwrb_n     = 1'b1;
    word        = W_DUMMY;
    req_ready_n = 1'b0;
    case (state_n)
      IDLE: req_ready_n = 1'b1;
      SYNC: begin
        csib_n = 1'b0; rdwrb_n = 1'b0;
        if (cnt_n == CW'(0))      word = W_DUMMY;
        else if (cnt_n == CW'(1)) word = W_SYNC;
        else                      word = W_NOOP;
      end
      HEADER: begin
        csib_n = 1'b0; rdwrb_n = 1'b0;
        word = W_HDR | (32'(addr_n) << 13);
      end
      PIPE: begin csib_n = 1'b0; rdwrb_n = 1'b0; word = W_NOOP; end
      TURN: rdwrb_n = (cnt_n != CW'(0));
      READ: csib_n = 1'b0;
      DESYNC:
        if (cnt_n == CW'(1)) rdwrb_n = 1'b0;
        else if (cnt_n >= CW'(2) && cnt_n <= CW'(6)) begin
          csib_n = 1'b0; rdwrb_n = 1'b0;
          if (cnt_n == CW'(3))      word = W_CMD_WR;
          else if (cnt_n == CW'(4)) word = W_DESYNC;
          else                      word = W_NOOP;
        end
      default: ;
    endcase
    icap_i_n = wire_fmt(word);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= BOOT;
      cnt            <= '0;
      addr_q         <= '0;
      cap_q          <= '0;
      bus.boot_done  <= 1'b0;
      bus.req_ready  <= 1'b0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_data   <= '0;
      bus.icap_csib  <= 1'b1;
      bus.icap_rdwrb <= 1'b1;
      bus.icap_i     <= 32'hFFFF_FFFF;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      addr_q         <= addr_n;
      cap_q          <= cap_n;
      bus.boot_done  <= boot_done_n;
      bus.req_ready  <= req_ready_n;
      bus.rsp_valid  <= rsp_valid_n;
      bus.rsp_data   <= rsp_data_n;
      bus.icap_csib  <= csib_n;
      bus.icap_rdwrb <= rdwrb_n;
      bus.icap_i     <= icap_i_n;
    end
  end
endmodule

// File: tb/tb_icap_reg_reader.sv
// Directed bench for icap_reg_reader: instance a (BOOT 16, latency 3), instance b (BOOT 0, latency 5).
module tb_icap_reg_reader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  icap_reg_reader_if a_if();
  icap_reg_reader_if b_if();

  icap_reg_reader #(.BOOT_CYCLES(16), .READ_LATENCY(3)) u_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
  icap_reg_reader #(.BOOT_CYCLES(0),  .READ_LATENCY(5)) u_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] wire_word(input logic [31:0] w);
`ifdef ICAP_REG_READER_BITSWAP_EN
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = w[(i & ~7) | (7 - (i & 7))];
    return r;
`else
    return w;
`endif
  endfunction

  // Expected ICAP write stream of one transaction: 4 sync, header, 4 pipe, 5 desync
  function automatic logic [31:0] exp_wr(input int k, input logic [4:0] addr);
    logic [31:0] w;
    case (k)
      0:       w = 32'hFFFF_FFFF;
      1:       w = 32'hAA99_5566;
      4:       w = 32'h2800_0001 | (32'(addr) << 13);
      10:      w = 32'h3000_8001;
      11:      w = 32'h0000_000D;
      default: w = 32'h2000_0000;
    endcase
    return wire_word(w);
  endfunction

  // ICAP models: count read cycles (csib=0, rdwrb=1); valid data only at the expected cycle
  logic [31:0] a_data = 32'h0372_C093;
  logic [31:0] b_data = 32'h0BAD_F00D;
  int a_rd = 0;
  int b_rd = 0;
  always @(negedge clk) begin
    if (!a_if.icap_csib && a_if.icap_rdwrb) a_rd++; else a_rd = 0;
    a_if.icap_o = wire_word((a_rd == 3) ? a_data : 32'hDEAD_BEEF);
    if (!b_if.icap_csib && b_if.icap_rdwrb) b_rd++; else b_rd = 0;
    b_if.icap_o = wire_word((b_rd == 5) ? b_data : (b_rd == 3) ? 32'hDEAD_BEEF : 32'h0);
  end

  logic [31:0] wlog[$];
  bit mon_en = 1'b0;
  always @(negedge clk) begin
    if (!a_if.icap_csib && !a_if.icap_rdwrb) wlog.push_back(a_if.icap_i);
    if (mon_en) chk("rdy_rsp_excl", {31'd0, a_if.rsp_valid & a_if.req_ready}, 32'd0);
  end

  task automatic boot_wait();
    int na = 0;
    int nb = 0;
    bit csib_ok = 1'b1;
    bit rsp_seen = 1'b0;
    rst_n = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (!a_if.icap_csib) csib_ok = 1'b0;
      if (a_if.rsp_valid) rsp_seen = 1'b1;
      if (n == 15) chk("boot_early_ready", a_if.req_ready, 1'b0);
      if (a_if.boot_done && na == 0) begin
        na = n;
        chk("boot_ready_a", a_if.req_ready, 1'b1);
      end
      if (b_if.boot_done && nb == 0) nb = n;
    end
    chk("boot_cycles_a", na, 16);
    chk("boot_cycles_b", nb, 1);
    chk("boot_csib_high", csib_ok, 1'b1);
    chk("boot_no_rsp", rsp_seen, 1'b0);
  endtask

  task automatic txn_a(input logic [4:0] addr, input logic [31:0] want);
    int n;
    @(negedge clk);
    chk("idle_ready", a_if.req_ready, 1'b1);
    wlog.delete();
    a_if.req_valid = 1'b1;
    a_if.req_addr  = addr;
    @(negedge clk);
    a_if.req_valid = 1'b0;
    a_if.req_addr  = ~addr;
    n = 1;
    while (!a_if.rsp_valid && n < 40) begin @(negedge clk); n++; end
    chk("rsp_latency", n, 20);
    chk("rsp_data", a_if.rsp_data, want);
    @(negedge clk); n++;
    chk("rsp_pulse", a_if.rsp_valid, 1'b0);
    while (!a_if.req_ready && n < 60) begin @(negedge clk); n++; end
    chk("ready_latency", n, 29);
    chk("rsp_hold", a_if.rsp_data, want);
    chk("wr_count", wlog.size(), 14);
    for (int k = 0; k < 14 && k < wlog.size(); k++)
      chk($sformatf("wr_word%0d", k), wlog[k], exp_wr(k, addr));
  endtask

  task automatic b2b();
    int n = 0;
    int acc[$];
    @(negedge clk);
    wlog.delete();
    a_if.req_addr  = 5'h0C;
    a_if.req_valid = 1'b1;
    while (acc.size() < 3 && n < 120) begin
      if (a_if.req_ready) begin
        acc.push_back(n);
        if (acc.size() == 2) begin
          chk("b2b_wr_count1", wlog.size(), 14);
          chk("b2b_cmd_wr", wlog[10], wire_word(32'h3000_8001));
          chk("b2b_desync", wlog[11], wire_word(32'h0000_000D));
        end
        if (acc.size() == 3) begin
          chk("b2b_wr_count2", wlog.size(), 28);
          chk("b2b_resync", wlog[15], wire_word(32'hAA99_5566));
          chk("b2b_data", a_if.rsp_data, a_data);
        end
      end
      if (acc.size() < 3) begin @(negedge clk); n++; end
    end
    a_if.req_valid = 1'b0;
    chk("b2b_count", acc.size(), 3);
    if (acc.size() == 3) begin
      chk("b2b_gap1", acc[1] - acc[0], 29);
      chk("b2b_gap2", acc[2] - acc[1], 29);
    end
  endtask

  task automatic reset_abort();
    @(negedge clk);
    a_if.req_addr  = 5'h0C;
    a_if.req_valid = 1'b1;
    @(negedge clk);
    a_if.req_valid = 1'b0;
    repeat (13) @(negedge clk);
    chk("abort_in_read", {31'd0, !a_if.icap_csib && a_if.icap_rdwrb}, 32'd1);
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_csib", a_if.icap_csib, 1'b1);
    chk("abort_rdwrb", a_if.icap_rdwrb, 1'b1);
    chk("abort_icap_i", a_if.icap_i, 32'hFFFF_FFFF);
    chk("abort_boot_done", a_if.boot_done, 1'b0);
    chk("abort_rsp_data", a_if.rsp_data, 32'h0);
    @(negedge clk);
    chk("abort_no_rsp", a_if.rsp_valid, 1'b0);
    boot_wait();
    mon_en = 1'b1;
  endtask

  task automatic txn_b();
    int n;
    @(negedge clk);
    chk("b_idle_ready", b_if.req_ready, 1'b1);
    b_if.req_addr  = 5'h0C;
    b_if.req_valid = 1'b1;
    @(negedge clk);
    b_if.req_valid = 1'b0;
    n = 1;
    while (!b_if.rsp_valid && n < 40) begin @(negedge clk); n++; end
    chk("b_rsp_latency", n, 20);
    chk("b_rsp_data", b_if.rsp_data, 32'h0BAD_F00D);
  endtask

  initial begin
    a_if.req_valid = 1'b0;
    a_if.req_addr  = 5'h0;
    b_if.req_valid = 1'b0;
    b_if.req_addr  = 5'h0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", a_if.req_ready, 1'b0);
    chk("rst_boot_done", a_if.boot_done, 1'b0);
    chk("rst_rsp_valid", a_if.rsp_valid, 1'b0);
    chk("rst_rsp_data", a_if.rsp_data, 32'h0);
    chk("rst_csib", a_if.icap_csib, 1'b1);
    chk("rst_rdwrb", a_if.icap_rdwrb, 1'b1);
    chk("rst_icap_i", a_if.icap_i, 32'hFFFF_FFFF);

    boot_wait();
    mon_en = 1'b1;
    txn_a(5'h0C, 32'h0372_C093);
    chk("hdr_idcode", (wlog.size() > 4) ? wlog[4] : 32'h0, wire_word(32'h2801_8001));
    a_data = 32'h5A5A_1234;
    txn_a(5'h13, 32'h5A5A_1234);
    a_data = 32'hA5A5_0F0F;
    b2b();
    reset_abort();
    a_data = 32'h1357_9BDF;
    txn_a(5'h0C, 32'h1357_9BDF);
    txn_b();
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
